input_debouncer: RTL and testbench
==================================

# input_debouncer

Conditions a raw, asynchronous single-bit input (push-button, switch, external strobe) into a clean, clock-synchronous level for the register stages downstream. It synchronizes the input, rejects any change that is not stable for a programmable number of cycles, and emits one-cycle rise/fall pulses on each accepted transition. The block sits directly upstream of the data flip-flop stage and drives its data input.

## Interface
- STABLE_CYCLES, 16: consecutive synchronized samples at the new level required to accept a change; legal range ≥ 2.
- SYNC_STAGES, 2: synchronizer flop depth; legal range ≥ 2.
- RESET_LEVEL, 0: level loaded into the synchronizer and `dout` on reset (0 or 1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  1  raw asynchronous input.
- dout  output  1  debounced level (registered).
- rise  output  1  one-cycle pulse when `dout` goes 0→1 (registered).
- fall  output  1  one-cycle pulse when `dout` goes 1→0 (registered).
- busy  output  1  high while a candidate change is being qualified.

## Operation
- Synchronizer: SYNC_STAGES-deep flop chain on `din`. Its last stage is `s`; no other logic touches `din`.
- Counter `cnt`: width $clog2(STABLE_CYCLES+1); never wraps.
- FSM states: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
  - STABLE_LO: if s=1 → PEND_HI, cnt←1; else stay, cnt←0.
  - PEND_HI: if s=0 → STABLE_LO, cnt←0 (glitch rejected). Else if cnt=STABLE_CYCLES-1 → STABLE_HI, dout←1, rise←1, cnt←0. Else cnt←cnt+1.
  - STABLE_HI / PEND_LO: mirror of the above with levels inverted; acceptance sets dout←0, fall←1.
- Abort has priority: if `s` returns to the old level in the same cycle that cnt=STABLE_CYCLES-1, the change is rejected.
- `busy` = state ∈ {PEND_HI, PEND_LO}; decoded from the registered state.
- `rise` and `fall` are high for exactly one cycle, never both in the same cycle, and only together with a `dout` change.
- Continuous toggling faster than STABLE_CYCLES never changes `dout`.
- Reset (synchronous, highest priority):
  - every synchronizer flop ← RESET_LEVEL;
  - state ← STABLE_LO if RESET_LEVEL=0, else STABLE_HI;
  - dout ← RESET_LEVEL; rise, fall, busy ← 0; cnt ← 0.
  - Reset asserted during PEND_* discards the candidate; no pulse is emitted.

## Timing
- Latency: a `din` step held stable changes `dout` exactly SYNC_STAGES + STABLE_CYCLES rising edges after the first edge that samples the new level.
- `rise`/`fall` assert in the same cycle `dout` first shows the new value and deassert on the next edge.
- `busy` is high for STABLE_CYCLES-1 cycles before an accepted change, and low again in the cycle `dout` changes.
- Minimum accepted pulse width on `din`: STABLE_CYCLES cycles (plus synchronizer skew); any shorter pulse is filtered out.
- Outputs are valid on the first edge after reset deasserts.

## Test plan
- Reset: hold din=1 and reset=1 for 3 cycles (RESET_LEVEL=0) → dout=0, rise=fall=busy=0 during reset and on the first cycle after release.
- Clean rise (STABLE_CYCLES=4, SYNC_STAGES=2): step din 0→1 and hold → dout=1 exactly 6 edges after the step; rise high for exactly that one cycle; busy high for the 3 preceding cycles.
- Glitch reject: din high for 3 cycles, then low (STABLE_CYCLES=4) → dout stays 0, rise never asserts, busy returns to 0.
- Clean fall: from dout=1, step din→0 → dout=0 after 6 edges; single fall pulse; rise stays 0.
- Bounce: din toggles every cycle for 20 cycles, then holds 1 → exactly one rise pulse, 6 edges after the last toggle; no fall pulse.
- Reset mid-qualify: assert reset while busy=1 in PEND_HI → next cycle busy=0 and dout=0; no rise pulse. After release, din still 1 → normal acceptance after 6 edges.

Source files
------------

// File: rtl/input_debouncer.sv
// Synchronizes a raw async input and accepts a level change only after it holds for STABLE_CYCLES samples.
// Latency SYNC_STAGES + STABLE_CYCLES edges from din step to dout; no backpressure (free-running).
module input_debouncer #(
    parameter int STABLE_CYCLES = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int RESET_LEVEL   = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int            CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic          RST_LVL = (RESET_LEVEL != 0);
    localparam logic [CW-1:0] LAST    = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] ONE     = CW'(1);

    typedef enum logic [1:0] {
        STABLE_LO,
        PEND_HI,
        STABLE_HI,
        PEND_LO
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_nxt;
    logic                   dout_nxt;
    logic                   rise_nxt;
    logic                   fall_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= {SYNC_STAGES{RST_LVL}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
        end
    end

    assign s = sync[SYNC_STAGES-1];

    // A return to the old level wins over reaching the acceptance count.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dout_nxt  = dout;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            STABLE_LO: begin
                if (s) begin
                    state_nxt = PEND_HI;
                    cnt_nxt   = ONE;
                end else begin
                    cnt_nxt = '0;
                end
            end
            PEND_HI: begin
                if (!s) begin
                    state_nxt = STABLE_LO;
                    cnt_nxt   = '0;
                end else if (cnt == LAST) begin
                    state_nxt = STABLE_HI;
                    dout_nxt  = 1'b1;
                    rise_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    state_nxt = PEND_LO;
                    cnt_nxt   = ONE;
                end else begin
                    cnt_nxt = '0;
                end
            end
            PEND_LO: begin
                if (s) begin
                    state_nxt = STABLE_HI;
                    cnt_nxt   = '0;
                end else if (cnt == LAST) begin
                    state_nxt = STABLE_LO;
                    dout_nxt  = 1'b0;
                    fall_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            default: begin
                state_nxt = RST_LVL ? STABLE_HI : STABLE_LO;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RST_LVL ? STABLE_HI : STABLE_LO;
            cnt   <= '0;
            dout  <= RST_LVL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dout  <= dout_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

    assign busy = (state == PEND_HI) || (state == PEND_LO);

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer (STABLE_CYCLES=4, SYNC_STAGES=2): fixed vector table, corner sequences,
// then random din against a run-length reference model.
module tb_input_debouncer;

    localparam int STABLE = 4;
    localparam int SYNC   = 2;
    localparam int RLVL   = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic din = 1'b0;
    logic dout, rise, fall, busy;

    int n_chk  = 0;
    int n_fail = 0;

    input_debouncer #(
        .STABLE_CYCLES(STABLE),
        .SYNC_STAGES  (SYNC),
        .RESET_LEVEL  (RLVL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .din  (din),
        .dout (dout),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: din delayed by SYNC edges, then a run length of samples disagreeing with dout.
    bit m_q[$];
    bit m_dout, m_rise, m_fall, m_busy;
    int m_run;

    task automatic model_step(input bit r, input bit d);
        bit sv;
        if (r) begin
            m_q.delete();
            for (int i = 0; i < SYNC; i++) m_q.push_back(RLVL != 0);
            m_dout = (RLVL != 0);
            m_rise = 1'b0;
            m_fall = 1'b0;
            m_run  = 0;
        end else begin
            sv = m_q.pop_front();
            m_q.push_back(d);
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (sv != m_dout) begin
                m_run++;
                if (m_run == STABLE) begin
                    m_dout = sv;
                    m_rise = sv;
                    m_fall = !sv;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        m_busy = (m_run != 0);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit d);
        @(negedge clk);
        reset = r;
        din   = d;
        @(posedge clk);
        model_step(r, d);
        #1;
        chk("model_dout", int'(dout), int'(m_dout));
        chk("model_rise", int'(rise), int'(m_rise));
        chk("model_fall", int'(fall), int'(m_fall));
        chk("model_busy", int'(busy), int'(m_busy));
        chk("rise_fall_exclusive", int'(rise && fall), 0);
    endtask

    typedef struct packed {
        logic rst;
        logic d;
        logic e_dout;
        logic e_rise;
        logic e_fall;
        logic e_busy;
    } vec_t;

    vec_t tbl[31];

    initial begin
        int nr;
        int nf;
        int rise_at;
        int waited;
        bit hold;
        int hold_left;
        bit r;

        // {rst, din, dout, rise, fall, busy}: reset, clean rise, high-side glitch,
        // clean fall, low-side glitch aborted exactly at the acceptance count.
        tbl[0]  = 6'b11_0000; tbl[1]  = 6'b11_0000; tbl[2]  = 6'b11_0000;
        tbl[3]  = 6'b01_0000; tbl[4]  = 6'b01_0000; tbl[5]  = 6'b01_0001;
        tbl[6]  = 6'b01_0001; tbl[7]  = 6'b01_0001; tbl[8]  = 6'b01_1100;
        tbl[9]  = 6'b01_1000; tbl[10] = 6'b00_1000; tbl[11] = 6'b00_1000;
        tbl[12] = 6'b00_1001; tbl[13] = 6'b01_1001; tbl[14] = 6'b01_1001;
        tbl[15] = 6'b01_1000; tbl[16] = 6'b01_1000; tbl[17] = 6'b00_1000;
        tbl[18] = 6'b00_1000; tbl[19] = 6'b00_1001; tbl[20] = 6'b00_1001;
        tbl[21] = 6'b00_1001; tbl[22] = 6'b00_0010; tbl[23] = 6'b00_0000;
        tbl[24] = 6'b01_0000; tbl[25] = 6'b01_0000; tbl[26] = 6'b01_0001;
        tbl[27] = 6'b00_0001; tbl[28] = 6'b00_0001; tbl[29] = 6'b00_0000;
        tbl[30] = 6'b00_0000;

        for (int i = 0; i < 31; i++) begin
            cyc(tbl[i].rst, tbl[i].d);
            chk($sformatf("tbl%0d_dout", i), int'(dout), int'(tbl[i].e_dout));
            chk($sformatf("tbl%0d_rise", i), int'(rise), int'(tbl[i].e_rise));
            chk($sformatf("tbl%0d_fall", i), int'(fall), int'(tbl[i].e_fall));
            chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].e_busy));
        end

        // Bounce: 20 cycles of toggling, then hold high; one rise 6 edges after the last toggle.
        nr = 0;
        nf = 0;
        rise_at = -1;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, (i % 2) == 0);
            nr += int'(rise);
            nf += int'(fall);
        end
        chk("bounce_no_change", int'(dout), 0);
        for (int k = 1; k <= 10; k++) begin
            cyc(1'b0, 1'b1);
            if (rise) rise_at = k;
            nr += int'(rise);
            nf += int'(fall);
        end
        chk("bounce_rise_count", nr, 1);
        chk("bounce_fall_count", nf, 0);
        chk("bounce_rise_edge", rise_at, SYNC + STABLE);

        // Reset while qualifying a rise discards the candidate.
        for (int k = 0; k < 8; k++) cyc(1'b0, 1'b0);
        chk("midq_low", int'(dout), 0);
        waited = 0;
        while (!busy && waited < 10) begin
            cyc(1'b0, 1'b1);
            waited++;
        end
        chk("midq_busy_edge", waited, SYNC + 1);
        cyc(1'b1, 1'b1);
        chk("midq_rst_busy", int'(busy), 0);
        chk("midq_rst_dout", int'(dout), 0);
        chk("midq_rst_rise", int'(rise), 0);
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b0, 1'b1);
            chk($sformatf("midq_rel%0d_dout", k), int'(dout), int'(k >= SYNC + STABLE));
            chk($sformatf("midq_rel%0d_rise", k), int'(rise), int'(k == SYNC + STABLE));
        end

        // Random hold lengths around the acceptance threshold, with sparse resets.
        hold = 1'b1;
        hold_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold_left == 0) begin
                hold = bit'($urandom_range(0, 1));
                hold_left = $urandom_range(1, 9);
            end
            hold_left--;
            r = ($urandom_range(0, 299) == 0);
            cyc(r, hold);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
